// File: rtl/demux_1to16_1bit_collect_pkg.sv
// Purpose : shared types and constants for the 1-to-16 bit collector.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package demux_pkg;

  localparam int LANES = 16;
  localparam int SEL_W = 4;

  localparam logic [LANES-1:0] MASK_FULL = 16'hFFFF;

  // COLLECT: accepting bits into the holding word.
  // HOLD   : word presented downstream, waiting for a pop.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/demux_1to16_1bit_collect_dec_4to16.sv
// Purpose : combinational 4-to-16 one-hot decoder with enable.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; all-zero output whenever i_en is low.
// Ports   : i_sel  - lane index 0..15
//           i_en   - decode enable; when low i_sel is ignored
//           o_onehot - one-hot lane enables (zero when disabled)
module dec_4to16
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [LANES-1:0] o_onehot
);

  // Gating on i_en first keeps an undriven i_sel from reaching the output.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_1to16_1bit_collect.sv
// Purpose : steer tagged single bits into a 16-bit word, emit when full or flushed.
// Latency : o_valid one cycle after the filling write or the flush.
// Backpr. : o_ready low while a word is held; held until downstream i_ready pops it.
// Ports   : i_clk, i_rst_n (async, active-low)
//           upstream   : i_valid, i_bit, i_sel, i_flush -> o_ready
//           downstream : o_valid, o_word, o_mask <- i_ready
//           o_dup      : one-cycle pulse after a write to an already-written lane
module demux_1to16_1bit_collect
  import demux_pkg::*;
#(
  parameter bit               FLUSH_EMPTY_EN = 1'b0,
  parameter logic [LANES-1:0] RST_WORD       = 16'h0000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_ready,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LANES-1:0] o_word,
  output logic [LANES-1:0] o_mask,
  output logic             o_dup
);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             pop;
  logic [LANES-1:0] lane_we;
  logic [LANES-1:0] word_d;
  logic [LANES-1:0] mask_d;
  logic             dup_hit;

  assign accept = i_valid & o_ready;
  assign pop    = o_valid & i_ready;

  dec_4to16 u_dec (
    .i_sel    (i_sel),
    .i_en     (accept),
    .o_onehot (lane_we)
  );

  // Only the addressed lane takes the new bit; the rest hold.
  assign word_d  = (o_word & ~lane_we) | ({LANES{i_bit}} & lane_we);
  assign mask_d  = o_mask | lane_we;
  assign dup_hit = |(lane_we & o_mask);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. The flush decision looks at mask_d so a bit accepted in
  // the flush cycle counts toward "something was written".
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: begin
        if ((mask_d == MASK_FULL) ||
            (i_flush && ((mask_d != '0) || FLUSH_EMPTY_EN))) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (i_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Output decode: ready is the only combinational output.
  always_comb begin
    o_ready = (state_q == COLLECT);
  end

  // Holding registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_word  <= RST_WORD;
      o_mask  <= '0;
      o_valid <= 1'b0;
      o_dup   <= 1'b0;
    end else begin
      o_valid <= (state_d == HOLD);
      o_dup   <= dup_hit;
      if (pop) begin
        o_word <= RST_WORD;
        o_mask <= '0;
      end else if (accept) begin
        o_word <= word_d;
        o_mask <= mask_d;
      end
    end
  end

endmodule

// File: tb/tb_demux_1to16_1bit_collect.sv
module tb_demux_1to16_1bit_collect;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        i_bit;
  logic [3:0]  i_sel;
  logic        i_flush;
  logic        i_ready;

  // Index 0: FLUSH_EMPTY_EN=0, index 1: FLUSH_EMPTY_EN=1. Same stimulus.
  logic [1:0]  o_ready;
  logic [1:0]  o_valid;
  logic [1:0]  o_dup;
  logic [15:0] o_word [2];
  logic [15:0] o_mask [2];

  int n_assert = 0;
  int n_fail   = 0;

  demux_1to16_1bit_collect #(.FLUSH_EMPTY_EN(1'b0), .RST_WORD(16'h0000)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_bit(i_bit),
    .i_sel(i_sel), .o_ready(o_ready[0]), .i_flush(i_flush), .o_valid(o_valid[0]),
    .i_ready(i_ready), .o_word(o_word[0]), .o_mask(o_mask[0]), .o_dup(o_dup[0])
  );

  demux_1to16_1bit_collect #(.FLUSH_EMPTY_EN(1'b1), .RST_WORD(16'h0000)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_bit(i_bit),
    .i_sel(i_sel), .o_ready(o_ready[1]), .i_flush(i_flush), .o_valid(o_valid[1]),
    .i_ready(i_ready), .o_word(o_word[1]), .o_mask(o_mask[1]), .o_dup(o_dup[1])
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: a word is either being collected or being held.
  bit          m_hold [2];
  logic [15:0] m_word [2];
  logic [15:0] m_mask [2];
  bit          m_dup  [2];

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_hold[k] = 0; m_word[k] = 16'h0000; m_mask[k] = 16'h0000; m_dup[k] = 0;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      if (m_hold[k]) begin
        m_dup[k] = 0;
        if (i_ready) begin
          m_hold[k] = 0; m_word[k] = 16'h0000; m_mask[k] = 16'h0000;
        end
      end else begin
        m_dup[k] = 0;
        if (i_valid) begin
          m_dup[k] = m_mask[k][i_sel];
          m_word[k][i_sel] = i_bit;
          m_mask[k][i_sel] = 1'b1;
        end
        if (m_mask[k] == 16'hFFFF) m_hold[k] = 1;
        else if (i_flush && (m_mask[k] != 16'h0000 || k == 1)) m_hold[k] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_valid", k), {15'd0, o_valid[k]}, {15'd0, m_hold[k]});
      chk($sformatf("d%0d_ready", k), {15'd0, o_ready[k]}, {15'd0, !m_hold[k]});
      chk($sformatf("d%0d_word", k), o_word[k], m_word[k]);
      chk($sformatf("d%0d_mask", k), o_mask[k], m_mask[k]);
      chk($sformatf("d%0d_dup", k), {15'd0, o_dup[k]}, {15'd0, m_dup[k]});
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic [3:0] s,
                       input logic f, input logic r);
    i_valid = v; i_bit = b; i_sel = s; i_flush = f; i_ready = r;
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge i_clk);
    if (i_rst_n) m_step();
    #1;
    check_model();
  endtask

  logic [15:0] pat;

  initial begin
    drive(0, 0, 4'd0, 0, 0);
    i_rst_n = 1'b0;
    m_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_word",  o_word[k], 16'h0000);
      chk("rst_mask",  o_mask[k], 16'h0000);
      chk("rst_valid", {15'd0, o_valid[k]}, 16'd0);
      chk("rst_ready", {15'd0, o_ready[k]}, 16'd1);
      chk("rst_dup",   {15'd0, o_dup[k]},   16'd0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // In-order fill with 16'hA5C3.
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      drive(1, pat[i], i[3:0], 0, 0);
      tick();
      if (i == 14) chk("fill_not_yet_valid", {15'd0, o_valid[0]}, 16'd0);
    end
    drive(0, 0, 4'd0, 0, 0);
    chk("fill_valid", {15'd0, o_valid[0]}, 16'd1);
    chk("fill_word",  o_word[0], 16'hA5C3);
    chk("fill_mask",  o_mask[0], 16'hFFFF);
    chk("fill_ready", {15'd0, o_ready[0]}, 16'd0);
    drive(0, 0, 4'd0, 0, 1);
    tick();

    // Reverse-order fill with 16'h1234 and a stalled pop; writes in HOLD ignored.
    pat = 16'h1234;
    for (int i = 15; i >= 0; i--) begin
      drive(1, pat[i], i[3:0], 0, 0);
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      drive(1, ~pat[c], c[3:0], 1, 0);
      tick();
      chk("stall_word",  o_word[0], 16'h1234);
      chk("stall_valid", {15'd0, o_valid[0]}, 16'd1);
    end
    drive(0, 0, 4'd0, 0, 1);
    tick();
    chk("pop_valid", {15'd0, o_valid[0]}, 16'd0);
    chk("pop_mask",  o_mask[0], 16'h0000);
    chk("pop_word",  o_word[0], 16'h0000);
    chk("pop_ready", {15'd0, o_ready[0]}, 16'd1);

    // Flush together with a write.
    drive(1, 1, 4'd2, 0, 0); tick();
    drive(1, 1, 4'd5, 0, 0); tick();
    drive(1, 1, 4'd7, 1, 0); tick();
    chk("flush_valid", {15'd0, o_valid[0]}, 16'd1);
    chk("flush_mask",  o_mask[0], 16'h00A4);
    chk("flush_word",  o_word[0], 16'h00A4);
    drive(0, 0, 4'd0, 0, 1); tick();

    // Empty flush: ignored unless FLUSH_EMPTY_EN.
    drive(0, 0, 4'd9, 1, 0); tick();
    chk("empty_flush_off", {15'd0, o_valid[0]}, 16'd0);
    chk("empty_flush_on",  {15'd0, o_valid[1]}, 16'd1);
    chk("empty_flush_mask", o_mask[1], 16'h0000);
    drive(0, 0, 4'd0, 0, 1); tick();

    // Duplicate write to lane 3.
    drive(1, 1, 4'd3, 0, 0); tick();
    chk("dup_first", {15'd0, o_dup[0]}, 16'd0);
    drive(1, 0, 4'd3, 0, 0); tick();
    chk("dup_pulse", {15'd0, o_dup[0]}, 16'd1);
    chk("dup_word3", {15'd0, o_word[0][3]}, 16'd0);
    chk("dup_mask3", {15'd0, o_mask[0][3]}, 16'd1);
    drive(0, 0, 4'd0, 0, 0); tick();
    chk("dup_once", {15'd0, o_dup[0]}, 16'd0);
    drive(0, 0, 4'd0, 1, 0); tick();
    drive(0, 0, 4'd0, 0, 1); tick();

    // Async reset while holding a word.
    drive(1, 1, 4'd0, 1, 0); tick();
    drive(1, 1, 4'd1, 0, 0); tick();
    drive(1, 1, 4'd2, 0, 0); tick();
    chk("hold_wr_ignored", o_word[0], 16'h0001);
    #2;
    i_rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_valid", {15'd0, o_valid[0]}, 16'd0);
    chk("arst_mask",  o_mask[0], 16'h0000);
    chk("arst_ready", {15'd0, o_ready[0]}, 16'd1);
    chk("arst_word",  o_word[0], 16'h0000);
    check_model();
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Randomised traffic; lane index left undriven when no bit is offered.
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_bit   = $urandom_range(0, 1);
      i_sel   = i_valid ? 4'($urandom_range(0, 15)) : 4'bxxxx;
      i_flush = ($urandom_range(0, 9) == 0);
      i_ready = $urandom_range(0, 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1to16_1bit_collect.md
Name: demux_1to16_1bit_collect

Overview:
- Write-side counterpart of the 16-to-1 bit selector.
- Accepts a stream of single bits, each tagged with a 4-bit lane index, and steers every bit into the addressed lane of a 16-bit holding register.
- Tracks which lanes have been written. When all 16 lanes are filled, or on an explicit flush, it presents the assembled word downstream with a valid/ready handshake.
- Used wherever bit-serial results must be regathered into a parallel word, e.g. flag/status assembly next to the pipeline register file.

Parameters:
- FLUSH_EMPTY_EN, 0, 1 = a flush with no lanes written still emits a word (mask all zero); 0 = such a flush is ignored.
- RST_WORD, 16'h0000, value loaded into the holding word at reset and after each pop.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous reset, active-low
- i_valid  input  1  upstream bit valid
- i_bit  input  1  data bit to steer
- i_sel  input  4  destination lane index, 0..15
- o_ready  output  1  block can accept a bit this cycle
- i_flush  input  1  close the current word early
- o_valid  output  1  assembled word available
- i_ready  input  1  downstream accepts the word
- o_word  output  16  assembled word; bit n = last bit written to lane n, else RST_WORD[n]
- o_mask  output  16  lane-written flags; bit n = 1 if lane n was written
- o_dup  output  1  one-cycle pulse: an accepted write hit an already-written lane

Behaviour:
- Interface: one clock, i_clk; reset i_rst_n, asynchronous, active-low.
- Reset values: state=COLLECT, o_word=RST_WORD, o_mask=0, o_valid=0, o_ready=1, o_dup=0.
- FSM has two states, COLLECT and HOLD.
- COLLECT:
  - o_ready=1, o_valid=0.
  - Accept = i_valid & o_ready. On accept: word[i_sel]<=i_bit and mask[i_sel]<=1, taking effect at the next edge.
  - Decoding is a full one-hot of i_sel. Only the addressed lane changes; all other lanes hold.
- Fill: if the accept makes the next mask 16'hFFFF, go to HOLD at the same edge. o_valid=1 from the next cycle, so latency is 1 cycle from the last write.
- Flush: i_flush in COLLECT, with or without a simultaneous accept:
  - the accepted bit is included;
  - go to HOLD if the resulting mask != 0, or if FLUSH_EMPTY_EN=1;
  - otherwise stay in COLLECT with no effect.
- HOLD:
  - o_valid=1, o_ready=0; i_valid and i_flush are ignored.
  - o_word and o_mask are stable until popped.
  - Pop = o_valid & i_ready. On pop: word<=RST_WORD, mask<=0, go to COLLECT. o_ready=1 from the next cycle. There is no bypass: a write in the pop cycle is not accepted.
- Duplicate write: an accept to a lane whose mask bit is already 1 overwrites the data bit and leaves the mask unchanged. o_dup=1 for exactly the following cycle (registered).
- Outputs o_word, o_mask, o_valid and o_dup are all registered; o_ready decodes directly from state.
- Reset mid-word: all partial data and mask are discarded immediately (asynchronous), even in HOLD with o_valid high.
- i_sel is don't-care when i_valid=0. No X may propagate into the word in that case.

Decomposition:
- Shared package demux_pkg:
  - state enum (COLLECT, HOLD);
  - localparams LANES=16 and SEL_W=4;
  - constant MASK_FULL=16'hFFFF.
- One sub-module is natural: dec_4to16, a combinational one-hot decoder (i_sel, i_en -> o_onehot[15:0]). It supplies the per-lane write enables and is reusable by register-file write ports.
- The FSM and the holding registers stay in the top block.

Test Plan:
- Fill in order: write lanes 0..15 with bits of 16'hA5C3 back to back -> o_valid=1 exactly 1 cycle after the lane-15 write, o_word=16'hA5C3, o_mask=16'hFFFF, o_ready=0.
- Out-of-order fill with a stalled pop: write lanes 15 down to 0 with 16'h1234, hold i_ready=0 for 5 cycles -> outputs stable for all 5 cycles. Then i_ready=1 -> next cycle o_valid=0, o_mask=0, o_word=RST_WORD, o_ready=1.
- Flush with concurrent write:
  - write lanes 2 and 5 with 1;
  - in the same cycle as a write to lane 7 with 1, assert i_flush;
  - expect o_valid=1 next cycle, o_mask=16'h00A4, o_word=16'h00A4.
- Empty flush: flush with mask=0 -> with FLUSH_EMPTY_EN=0, o_valid stays 0; with FLUSH_EMPTY_EN=1, o_valid=1 and o_mask=0.
- Duplicate write: lane 3 gets 1, then lane 3 gets 0 -> o_dup pulses once, the cycle after the second write. Word bit 3=0, mask bit 3=1.
- Async reset: assert i_rst_n=0 mid-cycle while in HOLD -> o_valid=0, o_mask=0, o_ready=1 immediately, without waiting for a clock edge. Writes in HOLD with i_valid=1 before the reset have no effect on o_word.
